// File: rtl/fxp_pkg.sv
// Shared Q2.14 format constants and the saturating-adder result type.
package fxp_pkg;
  localparam int FRAC_W = 14;
  localparam int INT_W  = 2;
  localparam int DATA_W = INT_W + FRAC_W;

  localparam logic [DATA_W-1:0] FXP_MAX = 16'h7FFF;
  localparam logic [DATA_W-1:0] FXP_MIN = 16'h8000;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              ovf;
    logic              udf;
  } fxp_res_t;
endpackage

// File: rtl/fxp_sat_add_core.sv
// Combinational Q2.14 saturating adder; clamps to FXP_MAX/FXP_MIN and flags which end was hit.
module fxp_sat_add_core
  import fxp_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output fxp_res_t          res
);
  logic [DATA_W:0] sum;

  always_comb begin
    sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    // Same-sign operands whose sum flips sign have left the representable range.
    res.ovf  = ~a[DATA_W-1] & ~b[DATA_W-1] &  sum[DATA_W-1];
    res.udf  =  a[DATA_W-1] &  b[DATA_W-1] & ~sum[DATA_W-1];
    res.data = sum[DATA_W-1:0];
    if (res.ovf)      res.data = FXP_MAX;
    else if (res.udf) res.data = FXP_MIN;
  end
endmodule

// File: rtl/fxp_add_arbiter.sv
// Round-robin front end sharing one two-stage saturating adder among NUM_REQ requesters,
// with tagged responses and saturating overflow/underflow event counters.
module fxp_add_arbiter
  import fxp_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int FRAC_WIDTH = FRAC_W,
  parameter int INT_WIDTH  = INT_W,
  parameter int NUM_REQ    = 4,
  parameter int CNT_WIDTH  = 16,
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_overflow,
  output logic                          rsp_underflow,
  input  logic                          cnt_clear,
  output logic [CNT_WIDTH-1:0]          ovf_count,
  output logic [CNT_WIDTH-1:0]          udf_count
);
  localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_REQ - 1);

  if (INT_WIDTH + FRAC_WIDTH != DATA_WIDTH) begin : g_bad_fmt
    $error("fxp_add_arbiter: INT_WIDTH + FRAC_WIDTH must equal DATA_WIDTH");
  end

  logic [ID_W-1:0]       last_q, last_d;
  logic                  s1_vld_q, s1_vld_d;
  logic [DATA_WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [ID_W-1:0]       s1_id_q, s1_id_d;
  logic                  s2_vld_q, s2_vld_d;
  fxp_res_t              s2_res_q, s2_res_d;
  logic [ID_W-1:0]       s2_id_q, s2_id_d;
  logic [CNT_WIDTH-1:0]  ovf_cnt_q, ovf_cnt_d, udf_cnt_q, udf_cnt_d;

  logic                  grant_vld;
  logic [ID_W-1:0]       grant_id;
  int                    idx;
  logic                  s2_adv, s1_acc, hs, rsp_hs;
  fxp_res_t              core_res;

  fxp_sat_add_core u_core (
    .a   (s1_a_q),
    .b   (s1_b_q),
    .res (core_res)
  );

  // Search begins one past the last winner so every waiting requester is reached within NUM_REQ grants.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_vld && req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_id  = ID_W'(idx);
      end
    end
  end

  always_comb begin
    s2_adv    = ~s2_vld_q | rsp_ready;
    s1_acc    = ~s1_vld_q | s2_adv;
    hs        = reset & grant_vld & s1_acc;
    rsp_hs    = s2_vld_q & rsp_ready;
    req_ready = '0;
    if (hs) req_ready[grant_id] = 1'b1;
  end

  always_comb begin
    last_d   = hs ? grant_id : last_q;
    s1_vld_d = hs | (s1_vld_q & ~s2_adv);
    s1_a_d   = hs ? req_a[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH] : s1_a_q;
    s1_b_d   = hs ? req_b[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH] : s1_b_q;
    s1_id_d  = hs ? grant_id : s1_id_q;

    s2_vld_d = s2_adv ? s1_vld_q : s2_vld_q;
    s2_res_d = (s2_adv & s1_vld_q) ? core_res : s2_res_q;
    s2_id_d  = (s2_adv & s1_vld_q) ? s1_id_q  : s2_id_q;

    // Clear dominates a same-cycle event; counters stick at all-ones.
    ovf_cnt_d = ovf_cnt_q;
    if (cnt_clear) ovf_cnt_d = '0;
    else if (rsp_hs && s2_res_q.ovf && !(&ovf_cnt_q)) ovf_cnt_d = ovf_cnt_q + CNT_WIDTH'(1);
    udf_cnt_d = udf_cnt_q;
    if (cnt_clear) udf_cnt_d = '0;
    else if (rsp_hs && s2_res_q.udf && !(&udf_cnt_q)) udf_cnt_d = udf_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_q    <= LAST_RST;
      s1_vld_q  <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_id_q   <= '0;
      s2_vld_q  <= 1'b0;
      s2_res_q  <= '0;
      s2_id_q   <= '0;
      ovf_cnt_q <= '0;
      udf_cnt_q <= '0;
    end else begin
      last_q    <= last_d;
      s1_vld_q  <= s1_vld_d;
      s1_a_q    <= s1_a_d;
      s1_b_q    <= s1_b_d;
      s1_id_q   <= s1_id_d;
      s2_vld_q  <= s2_vld_d;
      s2_res_q  <= s2_res_d;
      s2_id_q   <= s2_id_d;
      ovf_cnt_q <= ovf_cnt_d;
      udf_cnt_q <= udf_cnt_d;
    end
  end

  assign rsp_valid     = s2_vld_q;
  assign rsp_id        = s2_id_q;
  assign rsp_data      = s2_res_q.data;
  assign rsp_overflow  = s2_res_q.ovf;
  assign rsp_underflow = s2_res_q.udf;
  assign ovf_count     = ovf_cnt_q;
  assign udf_count     = udf_cnt_q;
endmodule

// File: tb/tb_fxp_add_arbiter.sv
// Scoreboard bench for fxp_add_arbiter: stimulus queues hand-computed responses, a negedge monitor checks them.
module tb_fxp_add_arbiter;
  localparam int NR = 4;
  localparam int DW = 16;
  localparam int CW = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    req_valid, req_ready;
  logic [NR*DW-1:0] req_a, req_b;
  logic             rsp_valid, rsp_ready;
  logic [1:0]       rsp_id;
  logic [DW-1:0]    rsp_data;
  logic             rsp_overflow, rsp_underflow, cnt_clear;
  logic [CW-1:0]    ovf_count, udf_count;

  always #5 clk = ~clk;

  fxp_add_arbiter #(.DATA_WIDTH(DW), .FRAC_WIDTH(14), .INT_WIDTH(2), .NUM_REQ(NR), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_overflow(rsp_overflow),
    .rsp_underflow(rsp_underflow), .cnt_clear(cnt_clear),
    .ovf_count(ovf_count), .udf_count(udf_count)
  );

  typedef struct {
    logic [1:0]    id;
    logic [DW-1:0] data;
    logic          ovf;
    logic          udf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   rsp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int id, input logic [DW-1:0] d, input logic o, input logic u);
    exp_t e;
    e.id = id[1:0]; e.data = d; e.ovf = o; e.udf = u;
    sb.push_back(e);
  endtask

  // Returns just after the edge on which the request was accepted.
  task automatic send(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    req_valid[i] = 1'b1;
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = req_ready[i];
    end
    chk("send_accept", 32'(got), 32'd1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
    chk("drain_empty", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && rsp_valid && rsp_ready) begin
      rsp_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got id %0d data %h expected no response", rsp_id, rsp_data);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp", 32'({rsp_id, rsp_data, rsp_overflow, rsp_underflow}),
            32'({mon_e.id, mon_e.data, mon_e.ovf, mon_e.udf}));
      end
    end
  end

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  logic [DW-1:0] sa[9] = '{16'h7FFF, 16'h8001, 16'hC000, 16'h4000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h2000};
  logic [DW-1:0] sbv[9] = '{16'h0001, 16'h8001, 16'hC000, 16'h3FFF, 16'h0001, 16'h7FFF, 16'h7FFF, 16'h8000, 16'hE000};
  logic [DW-1:0] se[9] = '{16'h7FFF, 16'h8000, 16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000};
  logic          so[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic          su[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [DW-1:0] rr_sum[4] = '{16'h0110, 16'h0210, 16'h0310, 16'h0410};
  logic [NR-1:0] bp_rdy[5] = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000};

  initial begin
    logic [31:0] snap;
    int r0, n;
    reset = 1'b0; req_valid = '1; req_a = '0; req_b = '0; rsp_ready = 1'b1; cnt_clear = 1'b0;

    // Reset state, with every requester asking.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp", 32'({rsp_id, rsp_data, rsp_overflow, rsp_underflow}), 32'd0);
    chk("rst_counts", {ovf_count, udf_count}, 32'd0);
    @(posedge clk); #1;
    req_valid = '0; reset = 1'b1;

    // Single op and latency.
    push(0, 16'h000F, 1'b0, 1'b0);
    send(0, 16'h000C, 16'h0003);
    @(negedge clk); chk("lat_edge_n", 32'(rsp_valid), 32'd0);
    @(negedge clk); chk("lat_edge_n1", 32'(rsp_valid), 32'd1);
    drain();

    // Saturation corners from rotating requesters.
    for (int i = 0; i < 9; i++) begin
      push(i % NR, se[i], so[i], su[i]);
      send(i % NR, sa[i], sbv[i]);
    end
    drain();
    chk("sat_ovf_count", 32'(ovf_count), 32'd2);
    chk("sat_udf_count", 32'(udf_count), 32'd2);

    // Fairness from a fresh pointer.
    reset = 1'b0; @(posedge clk); #1; reset = 1'b1;
    for (int i = 0; i < NR; i++) begin
      req_a[i*DW +: DW] = 16'((i + 1) * 256);
      req_b[i*DW +: DW] = 16'h0010;
    end
    r0 = rsp_cnt;
    req_valid = '1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("rr_grant", 32'(req_ready), 32'(1 << (c % NR)));
      push(c % NR, rr_sum[c % NR], 1'b0, 1'b0);
    end
    @(posedge clk); #1; req_valid = '0;
    drain();
    chk("rr_rsp_count", 32'(rsp_cnt - r0), 32'd8);

    // Backpressure: two accepts fill the pipe, outputs frozen.
    r0 = rsp_cnt; snap = '0;
    rsp_ready = 1'b0; req_valid = '1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_ready", 32'(req_ready), 32'(bp_rdy[c]));
      if (c < 2) push(c, rr_sum[c], 1'b0, 1'b0);
      if (c == 2) snap = 32'({rsp_valid, rsp_id, rsp_data, rsp_overflow, rsp_underflow});
      if (c > 2) chk("bp_stable", 32'({rsp_valid, rsp_id, rsp_data, rsp_overflow, rsp_underflow}), snap);
    end
    chk("bp_held_valid", snap[20], 1'b1);
    @(posedge clk); #1; req_valid = '0; rsp_ready = 1'b1;
    drain();
    repeat (3) @(posedge clk); #1;
    chk("bp_rsp_count", 32'(rsp_cnt - r0), 32'd2);

    // Counters: clear, count, clear-beats-increment, saturate.
    push(3, 16'h8000, 1'b0, 1'b1);
    send(3, 16'h8001, 16'h8001);
    drain();
    chk("cnt_udf_one", 32'(udf_count), 32'd1);
    cnt_clear = 1'b1; @(posedge clk); #1; cnt_clear = 1'b0;
    chk("cnt_cleared", {ovf_count, udf_count}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      push(1, 16'h7FFF, 1'b1, 1'b0);
      send(1, 16'h7FFF, 16'h0001);
    end
    drain();
    chk("cnt_ovf_three", 32'(ovf_count), 32'd3);
    push(1, 16'h7FFF, 1'b1, 1'b0);
    send(1, 16'h7FFF, 16'h0001);
    @(posedge clk); #1; cnt_clear = 1'b1;
    @(posedge clk); #1; cnt_clear = 1'b0;
    chk("cnt_clear_wins", 32'(ovf_count), 32'd0);
    chk("cnt_clear_sb", 32'(sb.size()), 32'd0);
    req_a[2*DW +: DW] = 16'h7FFF; req_b[2*DW +: DW] = 16'h0001;
    req_valid[2] = 1'b1;
    n = 0;
    for (int k = 0; k < 70000 && n < 65540; k++) begin
      @(negedge clk);
      if (req_ready[2]) begin
        push(2, 16'h7FFF, 1'b1, 1'b0);
        n++;
      end
    end
    chk("sat_ops_issued", 32'(n), 32'd65540);
    @(posedge clk); #1; req_valid = '0;
    drain();
    chk("cnt_ovf_hold", 32'(ovf_count), 32'h0000FFFF);
    chk("cnt_udf_idle", 32'(udf_count), 32'd0);

    // Mid-stream reset with both stages full.
    rsp_ready = 1'b0; req_valid = 4'b0011;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid_full_valid", 32'(rsp_valid), 32'd1);
    chk("mid_full_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1; req_valid = '1; reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_rsp", 32'({rsp_id, rsp_data, rsp_overflow, rsp_underflow}), 32'd0);
    chk("mid_rst_counts", {ovf_count, udf_count}, 32'd0);
    sb.delete();
    reset = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    chk("mid_first_grant", 32'(req_ready), 32'd1);
    push(0, 16'h0110, 1'b0, 1'b0);
    @(posedge clk); #1; req_valid = '0;
    drain();

    repeat (3) @(posedge clk);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fxp_add_arbiter.md
# fxp_add_arbiter

Shares one registered Q2.14 saturating adder between `NUM_REQ` independent requesters. Each requester submits operand pairs over a valid/ready channel. Grants rotate round-robin, and every result is returned on a single response channel tagged with the originating requester ID, together with overflow and underflow flags. The block also keeps saturating event counters for software visibility, and sits between the fixed-point producers and the shared arithmetic resource in the datapath.

## Interface
- `DATA_WIDTH`, 16, operand/result width (two's complement)
- `FRAC_WIDTH`, 14, fractional bits
- `INT_WIDTH`, 2, integer bits including sign; `INT_WIDTH + FRAC_WIDTH == DATA_WIDTH`
- `NUM_REQ`, 4, number of requesters (2..8)
- `CNT_WIDTH`, 16, event counter width
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-low reset
- `req_valid`  in  NUM_REQ  per-requester operand valid
- `req_ready`  out  NUM_REQ  per-requester accept; one-hot or zero
- `req_a`  in  NUM_REQ*DATA_WIDTH  operand A, requester i at slice [i*DATA_WIDTH +: DATA_WIDTH]
- `req_b`  in  NUM_REQ*DATA_WIDTH  operand B, same packing
- `rsp_valid`  out  1  result valid
- `rsp_ready`  in  1  downstream accept
- `rsp_id`  out  clog2(NUM_REQ)  requester index of the result
- `rsp_data`  out  DATA_WIDTH  saturated sum
- `rsp_overflow`  out  1  positive saturation occurred
- `rsp_underflow`  out  1  negative saturation occurred
- `cnt_clear`  in  1  synchronous clear of both counters
- `ovf_count`  out  CNT_WIDTH  overflow events issued, saturating
- `udf_count`  out  CNT_WIDTH  underflow events issued, saturating

## Operation
- **Arbitration.** Round-robin pointer `last`; search starts at `last+1` and wraps modulo NUM_REQ.
  - `req_ready[i]` is high only for the selected valid requester, and only when stage 1 can accept.
  - `last` updates only on a completed handshake (`req_valid[i] & req_ready[i]`).
  - `req_ready` is combinational from `req_valid` and pipeline state. Requesters must hold operands until accepted.
- **Stage 1 (operand register).** Holds A, B and the ID. It loads on a handshake and is empty otherwise.
- **Stage 2 (result register).** Drives the `rsp_*` outputs.
  - Sum is computed at DATA_WIDTH+1 bits.
  - Overflow: both operands non-negative and the sum exceeds `0x7FFF`. Then `rsp_data = 0x7FFF` and `rsp_overflow = 1`.
  - Underflow: both operands negative and the sum is below `0x8000`. Then `rsp_data = 0x8000` and `rsp_underflow = 1`.
  - Otherwise the result is the exact sum and both flags are 0. The two flags are never high together.
- **Backpressure.**
  - Stage 2 advances when it is empty or `rsp_ready = 1`.
  - Stage 1 advances into stage 2 under the same condition.
  - Stage 1 accepts a new request when it is empty or advancing.
  - Full throughput is one op per cycle.
- **Counters.**
  - Increment on each response handshake whose corresponding flag is set.
  - Hold at all-ones (no wrap).
  - `cnt_clear` wins over a simultaneous increment; the counter becomes 0.
- **Reset (`reset = 0`).** Applies at any point, including mid-transfer. All in-flight ops are dropped, and `last = NUM_REQ-1` so requester 0 has first priority. Reset values:
  - `rsp_valid = 0`, `req_ready = 0`
  - `rsp_data = 0`, `rsp_id = 0`, both flags 0
  - both counters 0

## Timing
- Request accepted at edge N, so the response is valid after edge N+1. Latency is 2 cycles with the pipeline unstalled.
- While `rsp_valid & ~rsp_ready`, the `rsp_*` outputs are held stable.
- During a stall, stage 1 holds its contents and no `req_ready` is asserted once stage 1 is full.
- Back-to-back requests from all requesters are served in strict rotation, with no requester granted twice while another waits.
- `req_ready` is low for the whole cycle in which `reset = 0`.

## Structure
- **Package `fxp_pkg`:**
  - Q2.14 constants `FXP_MAX = 16'h7FFF`, `FXP_MIN = 16'h8000`
  - width parameters
  - result struct typedef {data, ovf, udf}
- **Sub-module `fxp_sat_add_core`:** the combinational saturating adder (operands in, result struct out), instantiated in stage 2.
- **Top level:** the arbiter, the stage registers, the handshake logic and the counters.

## Test plan
- **Single op, no saturation.** Req0 sends A = `0x000C`, B = `0x0003` -> 2 cycles later `rsp_data = 0x000F`, `rsp_id = 0`, both flags 0.
- **Saturation.**
  - `0x7FFF + 0x0001` -> `0x7FFF` with `rsp_overflow = 1`.
  - `0x8001 + 0x8001` -> `0x8000` with `rsp_underflow = 1`.
  - `0xC000 + 0xC000` -> `0x8000` with no flag, since −2.0 is exactly representable.
- **Fairness.** All four requesters hold valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3, one response per cycle, IDs in the same order.
- **Backpressure.** `rsp_ready = 0` for 5 cycles under continuous requests -> at most 2 ops accepted, outputs stable throughout, no loss or duplication after release.
- **Counters.**
  - 3 overflowing ops -> `ovf_count = 3`.
  - `cnt_clear` asserted in the same cycle as a 4th overflow handshake -> `ovf_count = 0`.
  - Counter preloaded near max via repeated overflow ops -> holds at `0xFFFF`.
- **Mid-stream reset.** Assert `reset = 0` with both stages full -> next cycle `rsp_valid = 0` and all outputs at their reset values. The first post-reset grant goes to req0 when all requesters are valid.
